// File: rtl/lieat_sram_arbiter_if.sv
// Core-side request/response ports and sram_axi channels of the SRAM arbiter.
`timescale 1ns/1ps
interface lieat_sram_arbiter_if #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32
);
  // Core-side request channel, one slice per requester
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [5:0]          req_size;
  logic [127:0]        req_wdata;

  // Core-side response channel
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [63:0]         rsp_rdata;
  logic                rsp_err;

  // sram_axi read address / data
  logic                sram_axi_arvalid;
  logic                sram_axi_arready;
  logic [ADDR_W-1:0]   sram_axi_araddr;
  logic [2:0]          sram_axi_arsize;
  logic [ID_W-1:0]     sram_axi_arid;
  logic                sram_axi_rvalid;
  logic                sram_axi_rready;
  logic [63:0]         sram_axi_rdata;
  logic [ID_W-1:0]     sram_axi_rid;

  // sram_axi write address / data / response
  logic                sram_axi_awvalid;
  logic                sram_axi_awready;
  logic [ADDR_W-1:0]   sram_axi_awaddr;
  logic [2:0]          sram_axi_awsize;
  logic [ID_W-1:0]     sram_axi_awid;
  logic                sram_axi_wvalid;
  logic                sram_axi_wready;
  logic [63:0]         sram_axi_wdata;
  logic                sram_axi_bvalid;
  logic                sram_axi_bready;
  logic [1:0]          sram_axi_bresp;
  logic [ID_W-1:0]     sram_axi_bid;

  // Arbiter view
  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output sram_axi_arvalid, sram_axi_araddr, sram_axi_arsize, sram_axi_arid,
    input  sram_axi_arready,
    input  sram_axi_rvalid, sram_axi_rdata, sram_axi_rid,
    output sram_axi_rready,
    output sram_axi_awvalid, sram_axi_awaddr, sram_axi_awsize, sram_axi_awid,
    input  sram_axi_awready,
    output sram_axi_wvalid, sram_axi_wdata,
    input  sram_axi_wready,
    input  sram_axi_bvalid, sram_axi_bresp, sram_axi_bid,
    output sram_axi_bready
  );

  // Requesters plus SRAM model view
  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  sram_axi_arvalid, sram_axi_araddr, sram_axi_arsize, sram_axi_arid,
    output sram_axi_arready,
    output sram_axi_rvalid, sram_axi_rdata, sram_axi_rid,
    input  sram_axi_rready,
    input  sram_axi_awvalid, sram_axi_awaddr, sram_axi_awsize, sram_axi_awid,
    output sram_axi_awready,
    input  sram_axi_wvalid, sram_axi_wdata,
    output sram_axi_wready,
    output sram_axi_bvalid, sram_axi_bresp, sram_axi_bid,
    input  sram_axi_bready
  );
endinterface

// File: rtl/lieat_sram_arbiter.sv
// Round-robin two-requester arbiter for the single-beat sram_axi port.
// One transaction in flight; the issued AXI ID is the grant index.
`timescale 1ns/1ps
module lieat_sram_arbiter #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  lieat_sram_arbiter_if.slave   bus
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned SIZE_W = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AWW  = 3'd3,
    S_B    = 3'd4,
    S_RSP  = 3'd5
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e            state_q;
  logic              ptr_q;
  logic              gnt_q;
  req_t              req_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              any_req_c;
  logic              grant_c;
  logic              write_c;
  logic [1:0]        req_ready_c;
  req_t              sel_c;

  // Grant selection and request-slice mux; acceptance is only offered in IDLE
  always_comb begin
    any_req_c   = |bus.req_valid;
    grant_c     = bus.req_valid[ptr_q] ? ptr_q : ~ptr_q;
    write_c     = bus.req_write[grant_c];
    req_ready_c = 2'b00;
    sel_c       = '0;
    if ((state_q == S_IDLE) && any_req_c && !reset) begin
      req_ready_c = grant_c ? 2'b10 : 2'b01;
    end
    sel_c.addr  = grant_c ? bus.req_addr[ADDR_W +: ADDR_W] : bus.req_addr[0 +: ADDR_W];
    sel_c.size  = grant_c ? bus.req_size[5:3] : bus.req_size[2:0];
    sel_c.wdata = grant_c ? bus.req_wdata[127:64] : bus.req_wdata[63:0];
  end

  // Transaction sequencer: state, round-robin pointer and all registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      req_q       <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req_c) begin
            gnt_q <= grant_c;
            ptr_q <= ~grant_c;
            req_q <= sel_c;
            if (write_c) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_AWW;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (bus.sram_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (bus.sram_axi_rvalid) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= bus.sram_axi_rdata;
            rsp_err_q   <= (bus.sram_axi_rid != ID_W'(gnt_q));
            rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
            state_q     <= S_RSP;
          end
        end
        S_AWW: begin
          // AW and W complete independently; leave once neither is still pending
          if (bus.sram_axi_awready) awvalid_q <= 1'b0;
          if (bus.sram_axi_wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || bus.sram_axi_awready) &&
              (!wvalid_q  || bus.sram_axi_wready)) begin
            bready_q <= 1'b1;
            state_q  <= S_B;
          end
        end
        S_B: begin
          if (bus.sram_axi_bvalid) begin
            bready_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= (bus.sram_axi_bresp != 2'b00) ||
                           (bus.sram_axi_bid != ID_W'(gnt_q));
            rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
            state_q     <= S_RSP;
          end
        end
        S_RSP: begin
          if (bus.rsp_ready[gnt_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output drive from registers (req_ready is the only combinational output)
  assign bus.req_ready        = req_ready_c;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_rdata        = rsp_rdata_q;
  assign bus.rsp_err          = rsp_err_q;
  assign bus.sram_axi_arvalid = arvalid_q;
  assign bus.sram_axi_araddr  = req_q.addr;
  assign bus.sram_axi_arsize  = req_q.size;
  assign bus.sram_axi_arid    = ID_W'(gnt_q);
  assign bus.sram_axi_rready  = rready_q;
  assign bus.sram_axi_awvalid = awvalid_q;
  assign bus.sram_axi_awaddr  = req_q.addr;
  assign bus.sram_axi_awsize  = req_q.size;
  assign bus.sram_axi_awid    = ID_W'(gnt_q);
  assign bus.sram_axi_wvalid  = wvalid_q;
  assign bus.sram_axi_wdata   = req_q.wdata;
  assign bus.sram_axi_bready  = bready_q;

endmodule

// File: tb/tb_lieat_sram_arbiter.sv
// Directed self-checking bench for lieat_sram_arbiter.
`timescale 1ns/1ps
module tb_lieat_sram_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  lieat_sram_arbiter_if #(.ID_W(4), .ADDR_W(32)) bus ();

  lieat_sram_arbiter #(.ID_W(4), .ADDR_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Advance to 2ns after the next rising edge
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    bus.req_valid        = 2'b00;
    bus.req_write        = 2'b00;
    bus.req_addr         = '0;
    bus.req_size         = '0;
    bus.req_wdata        = '0;
    bus.rsp_ready        = 2'b00;
    bus.sram_axi_arready = 1'b0;
    bus.sram_axi_rvalid  = 1'b0;
    bus.sram_axi_rdata   = '0;
    bus.sram_axi_rid     = '0;
    bus.sram_axi_awready = 1'b0;
    bus.sram_axi_wready  = 1'b0;
    bus.sram_axi_bvalid  = 1'b0;
    bus.sram_axi_bresp   = 2'b00;
    bus.sram_axi_bid     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.req_valid = 2'b11;
    repeat (2) step();
    checks++;
    if ({bus.sram_axi_arvalid, bus.sram_axi_awvalid, bus.sram_axi_wvalid, bus.sram_axi_rready,
         bus.sram_axi_bready, bus.rsp_valid, bus.req_ready, bus.rsp_err} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ar%b aw%b w%b r%b b%b rv%b rr%b e%b, required all 0",
               bus.sram_axi_arvalid, bus.sram_axi_awvalid, bus.sram_axi_wvalid, bus.sram_axi_rready,
               bus.sram_axi_bready, bus.rsp_valid, bus.req_ready, bus.rsp_err);
    end
    checks++;
    if ({bus.sram_axi_araddr, bus.sram_axi_arid, bus.sram_axi_wdata, bus.rsp_rdata, bus.sram_axi_awsize} !== '0) begin
      errors++;
      $display("FAIL reset_data: got araddr %h arid %h wdata %h rdata %h, required 0",
               bus.sram_axi_araddr, bus.sram_axi_arid, bus.sram_axi_wdata, bus.rsp_rdata);
    end
    bus.req_valid = 2'b00;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    bus.req_write = 2'b00;
    bus.req_addr  = {32'h0, 32'h8000_0010};
    bus.req_size  = {3'd0, 3'd3};
    bus.req_valid = 2'b01;
    bus.sram_axi_arready = 1'b1;
    bus.sram_axi_rvalid  = 1'b1;
    bus.sram_axi_rdata   = 64'hDEAD_BEEF_0123_4567;
    bus.sram_axi_rid     = 4'd0;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL rd_accept: got %b required 01", bus.req_ready);
    end
    step();
    bus.req_valid = 2'b00;
    checks++;
    if ({bus.sram_axi_arvalid, bus.sram_axi_araddr, bus.sram_axi_arsize, bus.sram_axi_arid} !==
        {1'b1, 32'h8000_0010, 3'd3, 4'd0}) begin
      errors++;
      $display("FAIL rd_ar_c1: got v%b addr %h size %0d id %0d required v1 addr 80000010 size 3 id 0",
               bus.sram_axi_arvalid, bus.sram_axi_araddr, bus.sram_axi_arsize, bus.sram_axi_arid);
    end
    step();
    checks++;
    if ({bus.sram_axi_arvalid, bus.sram_axi_rready, bus.rsp_valid} !== 4'b0100) begin
      errors++;
      $display("FAIL rd_r_c2: got ar%b rr%b rv%b required ar0 rr1 rv00",
               bus.sram_axi_arvalid, bus.sram_axi_rready, bus.rsp_valid);
    end
    step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.sram_axi_rready} !==
        {2'b01, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rd_rsp_c3: got rv%b data %h err %b rr%b required rv01 data deadbeef01234567 err 0 rr0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.sram_axi_rready);
    end
    bus.rsp_ready = 2'b01;
    step();
    bus.rsp_ready = 2'b00;
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL rd_rsp_done: got %b required 00", bus.rsp_valid);
    end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_write = 2'b00;
    bus.req_addr  = {32'h2000_0004, 32'h1000_0000};
    bus.req_size  = {3'd2, 3'd3};
    bus.sram_axi_arready = 1'b1;
    bus.sram_axi_rvalid  = 1'b1;
    bus.rsp_ready = 2'b11;
    for (int t = 0; t < 4; t++) begin
      int g;
      g = t % 2;
      bus.sram_axi_rid   = 4'(g);
      bus.sram_axi_rdata = 64'(t + 100);
      #1;
      checks++;
      if (bus.req_ready !== ((g == 1) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_grant t%0d: got %b required grant %0d", t, bus.req_ready, g);
      end
      step();
      checks++;
      if ({bus.sram_axi_arid, bus.sram_axi_araddr} !== {4'(g), ((g == 1) ? 32'h2000_0004 : 32'h1000_0000)}) begin
        errors++;
        $display("FAIL rr_arid t%0d: got id %0d addr %h required id %0d", t, bus.sram_axi_arid, bus.sram_axi_araddr, g);
      end
      step();
      step();
      checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {((g == 1) ? 2'b10 : 2'b01), 1'b0, 64'(t + 100)}) begin
        errors++;
        $display("FAIL rr_rsp t%0d: got rv%b err %b data %h required rv for req %0d err 0 data %0d",
                 t, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, g, t + 100);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_write_delayed_aw();
    bus.req_valid = 2'b10;
    bus.req_write = 2'b10;
    bus.req_addr  = {32'h1000_0040, 32'h0};
    bus.req_size  = {3'd3, 3'd0};
    bus.req_wdata = {64'h1122_3344_5566_7788, 64'h0};
    bus.sram_axi_wready = 1'b1;
    bus.sram_axi_bvalid = 1'b1;
    bus.sram_axi_bid    = 4'd1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++; $display("FAIL wr_accept: got %b required 10", bus.req_ready);
    end
    step();
    bus.req_valid = 2'b00;
    checks++;
    if ({bus.sram_axi_awvalid, bus.sram_axi_wvalid, bus.sram_axi_wdata, bus.sram_axi_awid, bus.sram_axi_awaddr, bus.sram_axi_awsize} !==
        {2'b11, 64'h1122_3344_5566_7788, 4'd1, 32'h1000_0040, 3'd3}) begin
      errors++;
      $display("FAIL wr_aww_c1: got aw%b w%b data %h id %0d addr %h size %0d required aw1 w1 data 1122334455667788 id 1 addr 10000040 size 3",
               bus.sram_axi_awvalid, bus.sram_axi_wvalid, bus.sram_axi_wdata, bus.sram_axi_awid, bus.sram_axi_awaddr, bus.sram_axi_awsize);
    end
    for (int c = 2; c <= 4; c++) begin
      step();
      checks++;
      if ({bus.sram_axi_awvalid, bus.sram_axi_wvalid, bus.sram_axi_bready} !== 3'b100) begin
        errors++;
        $display("FAIL wr_aw_hold c%0d: got aw%b w%b b%b required aw1 w0 b0",
                 c, bus.sram_axi_awvalid, bus.sram_axi_wvalid, bus.sram_axi_bready);
      end
    end
    bus.sram_axi_awready = 1'b1;
    step();
    bus.sram_axi_awready = 1'b0;
    checks++;
    if ({bus.sram_axi_awvalid, bus.sram_axi_wvalid, bus.sram_axi_bready, bus.rsp_valid} !== 5'b00100) begin
      errors++;
      $display("FAIL wr_b_c5: got aw%b w%b b%b rv%b required aw0 w0 b1 rv00",
               bus.sram_axi_awvalid, bus.sram_axi_wvalid, bus.sram_axi_bready, bus.rsp_valid);
    end
    step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.sram_axi_bready} !== {2'b10, 1'b0, 64'h0, 1'b0}) begin
      errors++;
      $display("FAIL wr_rsp_c6: got rv%b err %b data %h b%b required rv10 err 0 data 0 b0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.sram_axi_bready);
    end
    bus.rsp_ready = 2'b10;
    step();
    idle_inputs();
  endtask

  task automatic test_errors();
    // write answered with SLVERR
    bus.req_valid = 2'b01;
    bus.req_write = 2'b01;
    bus.req_addr  = {32'h0, 32'h3000_0000};
    bus.req_wdata = {64'h0, 64'h0F0F_0F0F_0F0F_0F0F};
    bus.sram_axi_awready = 1'b1;
    bus.sram_axi_wready  = 1'b1;
    bus.sram_axi_bvalid  = 1'b1;
    bus.sram_axi_bresp   = 2'b10;
    step();
    bus.req_valid = 2'b00;
    step();
    step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_err} !== 3'b011) begin
      errors++; $display("FAIL err_bresp: got rv%b err %b required rv01 err 1", bus.rsp_valid, bus.rsp_err);
    end
    bus.rsp_ready = 2'b01;
    step();
    idle_inputs();
    // read answered with the wrong ID
    bus.req_valid = 2'b01;
    bus.sram_axi_arready = 1'b1;
    bus.sram_axi_rvalid  = 1'b1;
    bus.sram_axi_rid     = 4'd5;
    bus.sram_axi_rdata   = 64'h55;
    step();
    bus.req_valid = 2'b00;
    step();
    step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b01, 1'b1, 64'h55}) begin
      errors++;
      $display("FAIL err_rid: got rv%b err %b data %h required rv01 err 1 data 55", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    bus.rsp_ready = 2'b01;
    step();
    idle_inputs();
  endtask

  task automatic test_rsp_hold();
    // pointer is 1 here, so a lone req 1 read is granted, then req 0 wins next
    bus.req_valid = 2'b10;
    bus.req_addr  = {32'h4000_0008, 32'h0};
    bus.sram_axi_arready = 1'b1;
    bus.sram_axi_rvalid  = 1'b1;
    bus.sram_axi_rid     = 4'd1;
    bus.sram_axi_rdata   = 64'hCAFE_F00D_8BAD_F00D;
    step();
    bus.req_valid = 2'b00;
    step();
    step();
    bus.req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, bus.sram_axi_arvalid} !==
          {2'b10, 64'hCAFE_F00D_8BAD_F00D, 1'b0, 2'b00, 1'b0}) begin
        errors++;
        $display("FAIL hold c%0d: got rv%b data %h err %b rr%b ar%b required rv10 data cafef00d8badf00d err 0 rr00 ar0",
                 c, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, bus.sram_axi_arvalid);
      end
      step();
    end
    bus.rsp_ready = 2'b10;
    step();
    bus.rsp_ready = 2'b00;
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 4'b0001) begin
      errors++; $display("FAIL hold_release: got rv%b rr%b required rv00 rr01", bus.rsp_valid, bus.req_ready);
    end
    // both requesters withdraw before the edge: nothing is issued
    bus.req_valid = 2'b00;
    step();
    checks++;
    if ({bus.sram_axi_arvalid, bus.sram_axi_awvalid, bus.rsp_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL withdraw: got ar%b aw%b rv%b required all 0", bus.sram_axi_arvalid, bus.sram_axi_awvalid, bus.rsp_valid);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    // req 0 write moves the pointer to 1, then reset while awvalid is up
    bus.req_valid = 2'b01;
    bus.req_write = 2'b01;
    step();
    bus.req_valid = 2'b00;
    checks++;
    if ({bus.sram_axi_awvalid, bus.sram_axi_wvalid} !== 2'b11) begin
      errors++; $display("FAIL rst_aww: got aw%b w%b required 11", bus.sram_axi_awvalid, bus.sram_axi_wvalid);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.sram_axi_awvalid, bus.sram_axi_wvalid} !== 2'b00) begin
      errors++; $display("FAIL rst_async: got aw%b w%b required 00", bus.sram_axi_awvalid, bus.sram_axi_wvalid);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL rst_no_rsp: got %b required 00", bus.rsp_valid);
    end
    bus.req_valid = 2'b11;
    bus.req_write = 2'b00;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL rst_ptr: got %b required 01", bus.req_ready);
    end
    step();
    bus.req_valid = 2'b00;
    checks++;
    if ({bus.sram_axi_arvalid, bus.sram_axi_arid} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL rst_first_ar: got ar%b id %0d required ar1 id 0", bus.sram_axi_arvalid, bus.sram_axi_arid);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_delayed_aw();
    test_errors();
    test_rsp_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

endmodule
